lsu_sram_responder: RTL
=======================

Name: lsu_sram_responder

Overview:
Responder end of the LSU request/ack interface. It sits behind the external-memory channel of the LSU address demux and serves `lsu_req_t` transactions from a single-port synchronous SRAM. It supports loads, byte-strobed stores and word-size atomic read-modify-write operations. It returns a one-cycle `lsu_ack_t` pulse carrying read data or an error flag.

Parameters:
- BASE_ADDR, 32'h90000, byte base address of the served window; 4KB aligned.
- SIZE_BYTES, 32'h10000, window size in bytes; power of two, ≥4KB.
- RD_LAT, 1, SRAM read latency in cycles; legal values 1 or 2.
- AW, $clog2(SIZE_BYTES/4), localparam, SRAM word-address width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- lsu_req_i  in  SOPHON_PKG::lsu_req_t  request (req, we, addr[31:0], wdata[31:0], strb[3:0], size[1:0], amo[AMO_W-1:0]).
- lsu_ack_o  out  SOPHON_PKG::lsu_ack_t  response (ack, error, rdata[31:0]).
- sram_ce_o  out  1  SRAM chip enable, one cycle per access.
- sram_we_o  out  1  SRAM write enable, qualified by ce.
- sram_addr_o  out  AW  SRAM word address, taken from addr[AW+1:2].
- sram_be_o  out  4  SRAM byte enables for writes.
- sram_wdata_o  out  32  SRAM write data.
- sram_rdata_i  in  32  SRAM read data, valid RD_LAT cycles after a read ce.

Behaviour:
- Reset: every output is 0 (ack, error, rdata, ce, we, addr, be, wdata); FSM goes to IDLE.
- Interface protocol:
  - The initiator holds req and all fields stable until it samples ack.
  - ack is exactly one cycle wide.
  - rdata and error are valid only in the ack cycle; otherwise they are driven 0.
  - All outputs are registered or decoded from state; there is no combinational path from lsu_req_i to any output.
- FSM states: IDLE, ERR, WR, RD_WAIT, AMO_WR. Cycle 0 is the first cycle in which req is high while in IDLE; the request is latched on that edge.
- Decode in IDLE:
  - The request is in range iff BASE_ADDR <= addr < BASE_ADDR+SIZE_BYTES.
  - The request is misaligned iff (size==1 and addr[0]) or (size==2 and addr[1:0]!=0) or size==3.
  - amo!=AMO_NONE with size!=2 is an error.
  - Any error leads to ERR; otherwise amo!=AMO_NONE leads to RD_WAIT with the amo flag set, we=1 leads to WR, and we=0 leads to RD_WAIT.
- ERR: at cycle 1, ack=1, error=1, rdata=0, no SRAM access; then IDLE.
- WR: at cycle 1, ce=1, we=1, be=strb, wdata=wdata, and ack=1 in the same cycle; then IDLE. The responder writes strb as given; a zero strb is a legal no-op write that is still acked.
- Read:
  - ce=1, we=0 at cycle 1.
  - RD_WAIT counts RD_LAT cycles.
  - At cycle 1+RD_LAT, ack=1 and rdata=sram_rdata_i, captured unmodified as the full aligned word; the LSU performs sub-word extraction.
  - Then IDLE.
- AMO:
  - The read is issued at cycle 1; the old word is captured at cycle 1+RD_LAT.
  - AMO_WR at cycle 2+RD_LAT: ce=1, we=1, be=4'hF, wdata=amo_alu(old, wdata); ack=1 and rdata=old in the same cycle.
  - Then IDLE.
- Back-to-back requests: IDLE may accept a new request in the cycle immediately after an ack cycle. A req still high in the ack cycle itself is not sampled; the initiator drops req on the edge that samples ack.
- Req deasserted mid-transaction is a protocol violation. The responder completes the access and still pulses ack.
- rst_i asserted in any state: the next cycle is IDLE with all outputs 0. An in-flight access is abandoned with no ack, and an AMO write-back is not performed.
- amo_alu arithmetic:
  - 32-bit, wrap-around on ADD.
  - MIN/MAX are signed two's complement; MINU/MAXU are unsigned.
  - SWAP returns wdata.

Decomposition:
- Shared package (SOPHON_PKG): add AMO_W=4 and the amo encoding constants AMO_NONE=0, SWAP=1, ADD=2, AND=3, OR=4, XOR=5, MIN=6, MAX=7, MINU=8, MAXU=9. `lsu_req_t` and `lsu_ack_t` already live there.
- Sub-module: one combinational sub-module, lsu_amo_alu (inputs op, old, operand; output new word), shared with any future TCM-side atomic support.

Test Plan:
1. Word write addr=0x90010, wdata=0xDEADBEEF, strb=4'hF, then read of the same address with RD_LAT=1 -> write ack at cycle 1 with ce=we=1 and sram_addr=0x004; read ack at cycle 2 with rdata=0xDEADBEEF, error=0.
2. Byte write addr=0x90013, wdata=0xAB000000, strb=4'h8 over a word holding 0x11223344 -> be=4'h8 and the subsequent read returns 0xAB223344.
3. Out-of-range addr=0xA0000 and misaligned word addr=0x90002 -> each gets ack=1, error=1, rdata=0 at cycle 1, with no ce pulse.
4. AMO ADD: word=0xFFFFFFFF, wdata=2 -> at cycle 2+RD_LAT, ack with rdata=0xFFFFFFFF and SRAM write 0x00000001. AMO MIN: word=0x80000000, wdata=1 -> memory keeps 0x80000000. AMO MINU: same values -> memory becomes 0x00000001.
5. Back-to-back: a read then a write presented in the cycle after the first ack, with RD_LAT=2 -> read ack at cycle 3, write ce at cycle 5, write ack at cycle 5; no missed or duplicated acks.
6. rst_i asserted at cycle 1+RD_LAT of an AMO -> no ack; the SRAM word is unchanged; all outputs are 0 the cycle after reset; a following read completes normally.

Source files
------------

// File: rtl/sophon_pkg.sv
// Shared LSU interface types and atomic-operation encodings.
package SOPHON_PKG;

    localparam int unsigned AMO_W = 4;

    localparam logic [AMO_W-1:0] AMO_NONE = 4'd0;
    localparam logic [AMO_W-1:0] AMO_SWAP = 4'd1;
    localparam logic [AMO_W-1:0] AMO_ADD  = 4'd2;
    localparam logic [AMO_W-1:0] AMO_AND  = 4'd3;
    localparam logic [AMO_W-1:0] AMO_OR   = 4'd4;
    localparam logic [AMO_W-1:0] AMO_XOR  = 4'd5;
    localparam logic [AMO_W-1:0] AMO_MIN  = 4'd6;
    localparam logic [AMO_W-1:0] AMO_MAX  = 4'd7;
    localparam logic [AMO_W-1:0] AMO_MINU = 4'd8;
    localparam logic [AMO_W-1:0] AMO_MAXU = 4'd9;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic             req;
        logic             we;
        logic [31:0]      addr;
        logic [31:0]      wdata;
        logic [3:0]       strb;
        logic [1:0]       size;
        logic [AMO_W-1:0] amo;
    } lsu_req_t;

    typedef struct packed {
        logic        ack;
        logic        error;
        logic [31:0] rdata;
    } lsu_ack_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_WR,
        ST_RD_WAIT,
        ST_AMO_WR
    } resp_state_e;

    // Natural-alignment check for the access size; size 3 is never legal.
    function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
        return (size == 2'd3) ||
               ((size == SIZE_WORD) && (addr_lo != 2'b00)) ||
               ((size == SIZE_HALF) && addr_lo[0]);
    endfunction

endpackage

// File: rtl/lsu_amo_alu.sv
// Combinational atomic read-modify-write datapath for word-size AMOs.
module lsu_amo_alu
    import SOPHON_PKG::*;
(
    input  logic [AMO_W-1:0] op,
    input  logic [31:0]      old_word,
    input  logic [31:0]      operand,
    output logic [31:0]      new_word
);

    // Select the word to write back; unknown ops leave memory unchanged.
    always_comb begin
        new_word = old_word;
        case (op)
            AMO_SWAP: new_word = operand;
            AMO_ADD:  new_word = old_word + operand;
            AMO_AND:  new_word = old_word & operand;
            AMO_OR:   new_word = old_word | operand;
            AMO_XOR:  new_word = old_word ^ operand;
            AMO_MIN:  new_word = ($signed(old_word) < $signed(operand)) ? old_word : operand;
            AMO_MAX:  new_word = ($signed(old_word) > $signed(operand)) ? old_word : operand;
            AMO_MINU: new_word = (old_word < operand) ? old_word : operand;
            AMO_MAXU: new_word = (old_word > operand) ? old_word : operand;
            default:  new_word = old_word;
        endcase
    end

endmodule

// File: rtl/lsu_sram_responder.sv
// LSU request/ack responder serving loads, strobed stores and AMOs from a
// single-port synchronous SRAM. Outputs depend only on state and latched
// request fields (plus SRAM read data in the read-ack cycle).
module lsu_sram_responder
    import SOPHON_PKG::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h90000,
    parameter logic [31:0] SIZE_BYTES = 32'h10000,
    parameter int unsigned RD_LAT     = 1,
    localparam int unsigned AW        = $clog2(SIZE_BYTES / 4)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  lsu_req_t      lsu_req_i,
    output lsu_ack_t      lsu_ack_o,
    output logic          sram_ce_o,
    output logic          sram_we_o,
    output logic [AW-1:0] sram_addr_o,
    output logic [3:0]    sram_be_o,
    output logic [31:0]   sram_wdata_o,
    input  logic [31:0]   sram_rdata_i
);

    localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};
    localparam logic [1:0]  LAT_CNT  = 2'(RD_LAT);

    resp_state_e      state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [AW-1:0]    addr_q;
    logic [31:0]      wdata_q;
    logic [3:0]       strb_q;
    logic [AMO_W-1:0] amo_q;
    logic [31:0]      old_q;
    logic [31:0]      amo_new;
    logic             is_amo;
    logic             in_range;
    logic             req_err;
    logic             accept;

    assign is_amo   = (amo_q != AMO_NONE);
    assign accept   = (state_q == ST_IDLE) && lsu_req_i.req;
    assign in_range = (lsu_req_i.addr >= BASE_ADDR) && ({1'b0, lsu_req_i.addr} < END_ADDR);
    assign req_err  = !in_range ||
                      is_misaligned(lsu_req_i.addr[1:0], lsu_req_i.size) ||
                      ((lsu_req_i.amo != AMO_NONE) && (lsu_req_i.size != SIZE_WORD));

    lsu_amo_alu u_amo_alu (
        .op       (amo_q),
        .old_word (old_q),
        .operand  (wdata_q),
        .new_word (amo_new)
    );

    // State register and read-latency counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Latch the request fields on the accepting edge; they stay stable for the whole access.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            amo_q   <= AMO_NONE;
        end else if (accept) begin
            addr_q  <= lsu_req_i.addr[AW+1:2];
            wdata_q <= lsu_req_i.wdata;
            strb_q  <= lsu_req_i.strb;
            amo_q   <= lsu_req_i.amo;
        end
    end

    // Capture the pre-AMO memory word when the SRAM read data becomes valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            old_q <= '0;
        end else if ((state_q == ST_RD_WAIT) && (cnt_q == LAT_CNT) && is_amo) begin
            old_q <= sram_rdata_i;
        end
    end

    // Next-state decode: classify new requests in IDLE, count read latency in RD_WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (lsu_req_i.req) begin
                    cnt_d = '0;
                    if (req_err) begin
                        state_d = ST_ERR;
                    end else if ((lsu_req_i.amo != AMO_NONE) || !lsu_req_i.we) begin
                        state_d = ST_RD_WAIT;
                    end else begin
                        state_d = ST_WR;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == LAT_CNT) begin
                    state_d = is_amo ? ST_AMO_WR : ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            ST_ERR, ST_WR, ST_AMO_WR: state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Output decode from state; everything is zero unless the state drives it.
    always_comb begin
        lsu_ack_o    = '0;
        sram_ce_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_be_o    = '0;
        sram_wdata_o = '0;
        case (state_q)
            ST_ERR: begin
                lsu_ack_o.ack   = 1'b1;
                lsu_ack_o.error = 1'b1;
            end
            ST_WR: begin
                sram_ce_o     = 1'b1;
                sram_we_o     = 1'b1;
                sram_addr_o   = addr_q;
                sram_be_o     = strb_q;
                sram_wdata_o  = wdata_q;
                lsu_ack_o.ack = 1'b1;
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    sram_ce_o   = 1'b1;
                    sram_addr_o = addr_q;
                end
                if ((cnt_q == LAT_CNT) && !is_amo) begin
                    lsu_ack_o.ack   = 1'b1;
                    lsu_ack_o.rdata = sram_rdata_i;
                end
            end
            ST_AMO_WR: begin
                sram_ce_o       = 1'b1;
                sram_we_o       = 1'b1;
                sram_addr_o     = addr_q;
                sram_be_o       = 4'hF;
                sram_wdata_o    = amo_new;
                lsu_ack_o.ack   = 1'b1;
                lsu_ack_o.rdata = old_q;
            end
            default: ;
        endcase
    end

endmodule
